key_entry_ctrl: RTL and testbench

//  Keypad-to-operand front end for the calculator. It sits directly upstream of the arithmetic stage.

---
 rtl/key_entry_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_key_entry_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_entry_ctrl.sv
// Keypad front end for the calculator: turns key-press events into the operands, operator
// and strobes used by the arithmetic stage. Chained operators read the stage's answer back as V2.
module key_entry_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic [16:0] answer,
    output logic [16:0] V1,
    output logic [16:0] V2,
    output logic [1:0]  opcode,
    output logic        newop,
    output logic        newhex,
    output logic        eq,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ST_FIRST  = 2'b00,
        ST_OPWAIT = 2'b01,
        ST_SECOND = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [16:0]        v1_q, v1_d;
    logic [16:0]        v2_q, v2_d;
    logic [1:0]         opcode_q, opcode_d;
    logic               newop_q, newop_d;
    logic               newhex_q, newhex_d;
    logic               eq_q, eq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               kv_q, kv_d;

    logic               key_event;
    logic               is_digit;
    logic               is_op;
    logic               is_eq;
    logic               is_sign;
    logic               is_clr;
    logic [16:0]        v1_shifted;
    logic [16:0]        v1_fresh;
    logic               can_shift;

    // Only the rising edge of key_valid is a key press; codes above 0x15 are not keys.
    assign key_event  = key_valid & ~kv_q;
    assign is_digit   = key_event & ~key_code[4];
    assign is_op      = key_event & (key_code == 5'h10 || key_code == 5'h11 || key_code == 5'h12);
    assign is_eq      = key_event & (key_code == 5'h13);
    assign is_sign    = key_event & (key_code == 5'h14);
    assign is_clr     = key_event & (key_code == 5'h15);

    assign v1_shifted = {v1_q[16], v1_q[11:0], key_code[3:0]};
    assign v1_fresh   = {13'b0, key_code[3:0]};
    assign can_shift  = (cnt_q < CNT_W'(DIGITS));

    always_comb begin
        state_d  = state_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        opcode_d = opcode_q;
        cnt_d    = cnt_q;
        newop_d  = 1'b0;
        newhex_d = 1'b0;
        eq_d     = 1'b0;
        kv_d     = key_valid;

        if (is_clr) begin
            v1_d     = '0;
            v2_d     = '0;
            opcode_d = 2'b00;
            cnt_d    = '0;
            newop_d  = 1'b1;
            state_d  = ST_FIRST;
        end else begin
            case (state_q)
                ST_FIRST: begin
                    if (is_digit) begin
                        if (can_shift) begin
                            v1_d     = v1_shifted;
                            cnt_d    = cnt_q + CNT_W'(1);
                            newhex_d = 1'b1;
                        end
                    end else if (is_op) begin
                        v2_d     = v1_q;
                        v1_d     = '0;
                        cnt_d    = '0;
                        opcode_d = key_code[1:0];
                        newop_d  = 1'b1;
                        state_d  = ST_OPWAIT;
                    end else if (is_eq) begin
                        eq_d    = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_sign) begin
                        v1_d     = {~v1_q[16], v1_q[15:0]};
                        newhex_d = 1'b1;
                    end
                end
                ST_OPWAIT: begin
                    if (is_digit) begin
                        v1_d     = v1_fresh;
                        cnt_d    = CNT_W'(1);
                        newhex_d = 1'b1;
                        state_d  = ST_SECOND;
                    end else if (is_op) begin
                        opcode_d = key_code[1:0];
                        newop_d  = 1'b1;
                    end else if (is_eq) begin
                        eq_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_SECOND: begin
                    if (is_digit) begin
                        if (can_shift) begin
                            v1_d     = v1_shifted;
                            cnt_d    = cnt_q + CNT_W'(1);
                            newhex_d = 1'b1;
                        end
                    end else if (is_op) begin
                        // Chained calculation: the pending result becomes the held operand.
                        v2_d     = answer;
                        v1_d     = '0;
                        cnt_d    = '0;
                        opcode_d = key_code[1:0];
                        newop_d  = 1'b1;
                        state_d  = ST_OPWAIT;
                    end else if (is_eq) begin
                        eq_d    = 1'b1;
                        state_d = ST_DONE;
                    end else if (is_sign) begin
                        v1_d     = {~v1_q[16], v1_q[15:0]};
                        newhex_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (is_digit) begin
                        // A digit after a result starts a brand-new calculation.
                        v1_d     = v1_fresh;
                        v2_d     = '0;
                        opcode_d = 2'b00;
                        cnt_d    = CNT_W'(1);
                        newhex_d = 1'b1;
                        newop_d  = 1'b1;
                        state_d  = ST_FIRST;
                    end else if (is_op) begin
                        v2_d     = answer;
                        v1_d     = '0;
                        cnt_d    = '0;
                        opcode_d = key_code[1:0];
                        newop_d  = 1'b1;
                        state_d  = ST_OPWAIT;
                    end else if (is_eq) begin
                        eq_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FIRST;
            v1_q     <= '0;
            v2_q     <= '0;
            opcode_q <= 2'b00;
            cnt_q    <= '0;
            newop_q  <= 1'b0;
            newhex_q <= 1'b0;
            eq_q     <= 1'b0;
            kv_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
            newop_q  <= newop_d;
            newhex_q <= newhex_d;
            eq_q     <= eq_d;
            kv_q     <= kv_d;
        end
    end

    // kv_q resets high so a key already held at reset release is not seen as a press.
    assign V1        = v1_q;
    assign V2        = v2_q;
    assign opcode    = opcode_q;
    assign newop     = newop_q;
    assign newhex    = newhex_q;
    assign eq        = eq_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed, table-driven bench for key_entry_ctrl: key-press vectors with hand-computed
// expected outputs, plus hand-written sequences for held keys and asynchronous reset.
module tb_key_entry_ctrl;

    logic        clock;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [16:0] answer;
    logic [16:0] V1;
    logic [16:0] V2;
    logic [1:0]  opcode;
    logic        newop;
    logic        newhex;
    logic        eq;
    logic [1:0]  state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int hex_cnt = 0;
    int op_cnt  = 0;
    int eq_cnt  = 0;

    key_entry_ctrl #(.DIGITS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .answer    (answer),
        .V1        (V1),
        .V2        (V2),
        .opcode    (opcode),
        .newop     (newop),
        .newhex    (newhex),
        .eq        (eq),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (newhex) hex_cnt++;
        if (newop)  op_cnt++;
        if (eq)     eq_cnt++;
    end

    typedef struct {
        logic [4:0]  code;
        logic [16:0] ans;
        logic [16:0] v1;
        logic [16:0] v2;
        logic [1:0]  op;
        logic [1:0]  st;
        logic        nop;
        logic        nhex;
        logic        neq;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] F = 2'd0, W = 2'd1, S = 2'd2, D = 2'd3;

    function automatic vec_t mk(logic [4:0] code, logic [16:0] ans, logic [16:0] v1,
                                logic [16:0] v2, logic [1:0] op, logic [1:0] st,
                                logic nop, logic nhex, logic neq);
        vec_t v;
        v.code = code; v.ans = ans; v.v1 = v1; v.v2 = v2; v.op = op; v.st = st;
        v.nop = nop; v.nhex = nhex; v.neq = neq;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {23'b0, V1, V2, opcode, state_dbg, newop, newhex, eq};
    endfunction

    // One press: rising key_valid before a posedge, sample at the following negedge, release.
    task automatic press(input logic [4:0] code, input logic [16:0] ans);
        @(negedge clock);
        key_code  = code;
        answer    = ans;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        key_valid = 1'b1;
        key_code  = 5'h07;
        answer    = '0;

        // Test 1
        vecs.push_back(mk(5'h01, 0, 17'h00001, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h02, 0, 17'h00012, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h0A, 0, 17'h0012A, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h10, 0, 17'h00000, 17'h0012A, 0, W, 1, 0, 0));
        vecs.push_back(mk(5'h03, 0, 17'h00003, 17'h0012A, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h13, 0, 17'h00003, 17'h0012A, 0, D, 0, 0, 1));
        // Test 2: digit limit
        vecs.push_back(mk(5'h15, 0, 17'h00000, 17'h00000, 0, F, 1, 0, 0));
        vecs.push_back(mk(5'h01, 0, 17'h00001, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h02, 0, 17'h00012, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h03, 0, 17'h00123, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h04, 0, 17'h01234, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h05, 0, 17'h01234, 17'h00000, 0, F, 0, 0, 0));
        // Test 3: sign handling
        vecs.push_back(mk(5'h15, 0, 17'h00000, 17'h00000, 0, F, 1, 0, 0));
        vecs.push_back(mk(5'h05, 0, 17'h00005, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h14, 0, 17'h10005, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h11, 0, 17'h00000, 17'h10005, 1, W, 1, 0, 0));
        vecs.push_back(mk(5'h07, 0, 17'h00007, 17'h10005, 1, S, 0, 1, 0));
        vecs.push_back(mk(5'h14, 0, 17'h10007, 17'h10005, 1, S, 0, 1, 0));
        // Test 4: chaining, then OPWAIT/DONE corners
        vecs.push_back(mk(5'h15, 0, 17'h00000, 17'h00000, 0, F, 1, 0, 0));
        vecs.push_back(mk(5'h09, 0, 17'h00009, 17'h00000, 0, F, 0, 1, 0));
        vecs.push_back(mk(5'h12, 0, 17'h00000, 17'h00009, 2, W, 1, 0, 0));
        vecs.push_back(mk(5'h04, 0, 17'h00004, 17'h00009, 2, S, 0, 1, 0));
        vecs.push_back(mk(5'h10, 5, 17'h00000, 17'h00005, 0, W, 1, 0, 0));
        vecs.push_back(mk(5'h14, 5, 17'h00000, 17'h00005, 0, W, 0, 0, 0));
        vecs.push_back(mk(5'h11, 5, 17'h00000, 17'h00005, 1, W, 1, 0, 0));
        vecs.push_back(mk(5'h13, 5, 17'h00000, 17'h00005, 1, D, 0, 0, 1));
        vecs.push_back(mk(5'h14, 5, 17'h00000, 17'h00005, 1, D, 0, 0, 0));
        vecs.push_back(mk(5'h13, 5, 17'h00000, 17'h00005, 1, D, 0, 0, 1));
        vecs.push_back(mk(5'h12, 17'h10003, 17'h00000, 17'h10003, 2, W, 1, 0, 0));
        vecs.push_back(mk(5'h13, 17'h10003, 17'h00000, 17'h10003, 2, D, 0, 0, 1));
        vecs.push_back(mk(5'h08, 0, 17'h00008, 17'h00000, 0, F, 1, 1, 0));
        vecs.push_back(mk(5'h16, 0, 17'h00008, 17'h00000, 0, F, 0, 0, 0));
        vecs.push_back(mk(5'h1F, 0, 17'h00008, 17'h00000, 0, F, 0, 0, 0));
        vecs.push_back(mk(5'h0C, 0, 17'h0008C, 17'h00000, 0, F, 0, 1, 0));
        // Second-operand digit limit and overflowed (zero) answer
        vecs.push_back(mk(5'h15, 0, 17'h00000, 17'h00000, 0, F, 1, 0, 0));
        vecs.push_back(mk(5'h10, 0, 17'h00000, 17'h00000, 0, W, 1, 0, 0));
        vecs.push_back(mk(5'h0F, 0, 17'h0000F, 17'h00000, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h0E, 0, 17'h000FE, 17'h00000, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h0D, 0, 17'h00FED, 17'h00000, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h0C, 0, 17'h0FEDC, 17'h00000, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h0B, 0, 17'h0FEDC, 17'h00000, 0, S, 0, 0, 0));
        vecs.push_back(mk(5'h14, 0, 17'h1FEDC, 17'h00000, 0, S, 0, 1, 0));
        vecs.push_back(mk(5'h10, 0, 17'h00000, 17'h00000, 0, W, 1, 0, 0));

        // Reset state, with a key held high through reset release
        repeat (2) @(negedge clock);
        check("reset_state", outs(), 64'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("held_through_reset_v1", {47'b0, V1}, 64'd0);
        check("held_through_reset_hex", hex_cnt, 64'd0);
        key_valid = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            press(vecs[i].code, vecs[i].ans);
            check($sformatf("vec%0d code=%0h", i, vecs[i].code), outs(),
                  {23'b0, vecs[i].v1, vecs[i].v2, vecs[i].op, vecs[i].st,
                   vecs[i].nop, vecs[i].nhex, vecs[i].neq});
        end

        // Strobes last exactly one cycle
        @(negedge clock);
        check("strobes_drop", {61'b0, newop, newhex, eq}, 64'd0);

        // Test 5: key held high for 10 cycles gives one event
        press(5'h15, 0);
        hex_cnt = 0;
        @(negedge clock);
        key_code  = 5'h06;
        key_valid = 1'b1;
        repeat (10) @(negedge clock);
        key_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("held_key_newhex_count", hex_cnt, 64'd1);
        check("held_key_v1", {47'b0, V1}, 64'h6);

        // Test 6: async reset mid-entry
        press(5'h15, 0);
        press(5'h01, 0);
        press(5'h10, 0);
        press(5'h03, 0);
        press(5'h04, 0);
        check("pre_reset_entry", {45'b0, V1, state_dbg}, {45'b0, 17'h00034, S});
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", outs(), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        press(5'h07, 0);
        check("after_reset_fresh_entry", outs(), {23'b0, 17'h00007, 17'h0, 2'd0, F, 3'b010});

        // Clear from DONE gives exactly one newop
        press(5'h11, 0);
        press(5'h13, 0);
        check("reach_done", {62'b0, state_dbg}, {62'b0, D});
        op_cnt = 0;
        press(5'h15, 0);
        repeat (3) @(negedge clock);
        check("clear_from_done", outs(), 64'd0);
        check("clear_newop_count", op_cnt, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
